segment_scan_driver: RTL and testbench

// - Consumes the 3-bit scan index from the segment pulse generator and drives a

---
 rtl/segment_scan_driver_pkg.sv | 38 +++
 rtl/segment_scan_driver_hex_to_seg7.sv | 11 +
 rtl/segment_scan_driver.sv | 103 ++++++++++
 tb/tb_segment_scan_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/segment_scan_driver_pkg.sv
// Shared constants, buffer word type and the hex-to-7-segment table for the
// multiplexed display driver.
package segment_scan_driver_pkg;

    localparam int          DIGITS_DEF = 8;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;
    localparam logic [7:0]  AN_OFF     = 8'hFF;

    // One display frame: eight nibbles plus per-digit enable and decimal point.
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  mask;
        logic [7:0]  dp;
    } disp_word_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        case (nibble)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/segment_scan_driver_hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module hex_to_seg7
    import segment_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex7(nibble);

endmodule

// File: rtl/segment_scan_driver.sv
// Multiplexed 8-digit 7-segment driver: double-buffered frame data taken over a
// valid/ack handshake, swapped at index wrap, with anti-ghosting blanking.
module segment_scan_driver
    import segment_scan_driver_pkg::*;
#(
    parameter int DIGITS       = DIGITS_DEF,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        Origin_Clock,
    input  logic        reset,
    input  logic [2:0]  pulse,
    input  logic [31:0] data,
    input  logic [7:0]  data_mask,
    input  logic [7:0]  data_dp,
    input  logic        data_valid,
    output logic        data_ack,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int             CW         = $clog2(BLANK_CYCLES + 1);
    localparam logic [CW-1:0]  BLANK_LOAD = CW'(BLANK_CYCLES - 1);

    logic [2:0]     pulse_q;
    disp_word_t     pend_buf;
    disp_word_t     disp_buf;
    logic           pend_full;
    logic [CW-1:0]  blank_cnt;

    logic           change;
    logic           boundary;
    logic           drain;
    logic           accept;
    logic           show;
    logic [3:0]     nibble;
    logic [6:0]     seg_digit;

    assign change   = (pulse != pulse_q);
    assign boundary = change && (pulse == 3'd0);
    assign drain    = boundary && pend_full;
    // A draining pending slot can take a new word at the same edge.
    assign accept   = data_valid && (!pend_full || drain);

    assign nibble = disp_buf.data[{pulse_q, 2'b00} +: 4];
    assign show   = (int'(pulse_q) < DIGITS) && disp_buf.mask[pulse_q];

    hex_to_seg7 u_hex (
        .nibble (nibble),
        .seg    (seg_digit)
    );

    always_ff @(posedge Origin_Clock) begin
        if (!reset) begin
            pulse_q     <= 3'd0;
            pend_buf    <= '0;
            disp_buf    <= '0;
            pend_full   <= 1'b0;
            blank_cnt   <= BLANK_LOAD;
            data_ack    <= 1'b0;
            frame_start <= 1'b0;
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
        end else begin
            pulse_q     <= pulse;
            data_ack    <= accept;
            frame_start <= boundary;

            if (accept)
                pend_buf <= '{data: data, mask: data_mask, dp: data_dp};
            if (drain)
                disp_buf <= pend_buf;

            if (accept)
                pend_full <= 1'b1;
            else if (drain)
                pend_full <= 1'b0;

            if (change) begin
                blank_cnt <= BLANK_LOAD;
                an        <= AN_OFF;
                seg       <= SEG_BLANK;
                dp        <= 1'b1;
            end else if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - 1'b1;
                an        <= AN_OFF;
                seg       <= SEG_BLANK;
                dp        <= 1'b1;
            end else if (show) begin
                an        <= ~(8'd1 << pulse_q);
                seg       <= seg_digit;
                dp        <= ~disp_buf.dp[pulse_q];
            end else begin
                an        <= AN_OFF;
                seg       <= SEG_BLANK;
                dp        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_segment_scan_driver.sv
// Scoreboard bench: a frame-level reference model queues the expected outputs of
// every clock edge; a monitor on the falling edge pops and compares them.
module tb_segment_scan_driver;

    localparam int DIGITS       = 8;
    localparam int BLANK_CYCLES = 16;

    logic        clk;
    logic        reset;
    logic [2:0]  pulse;
    logic [31:0] data;
    logic [7:0]  data_mask;
    logic [7:0]  data_dp;
    logic        data_valid;
    logic        data_ack;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    segment_scan_driver #(.DIGITS(DIGITS), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .Origin_Clock (clk),
        .reset        (reset),
        .pulse        (pulse),
        .data         (data),
        .data_mask    (data_mask),
        .data_dp      (data_dp),
        .data_valid   (data_valid),
        .data_ack     (data_ack),
        .an           (an),
        .seg          (seg),
        .dp           (dp),
        .frame_start  (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ack;
        logic       fs;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  m;
        logic [7:0]  p;
    } word_t;

    // Segment patterns written out independently of the design's package.
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t  exp_q[$];
    word_t send_q[$];
    int    errors = 0;
    int    checks = 0;

    // ---------------- reference model ----------------
    int    m_since;
    int    m_prev;
    word_t m_disp;
    word_t m_pend[$];

    always @(posedge clk) begin
        exp_t  e;
        word_t w;
        bit    chg, bnd, drn, acc;
        e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.ack = 1'b0; e.fs = 1'b0;
        if (!reset) begin
            m_since = 0;
            m_prev  = 0;
            m_disp  = '{d: 32'h0, m: 8'h0, p: 8'h0};
            m_pend.delete();
        end else begin
            chg = (int'(pulse) != m_prev);
            bnd = chg && (pulse == 3'd0);
            if (chg) m_since = 0;
            else if (m_since < 1000) m_since++;
            // A digit lights once BLANK_CYCLES edges have passed since its index arrived.
            if (m_since >= BLANK_CYCLES && m_prev < DIGITS && m_disp.m[m_prev]) begin
                e.an  = ~(8'd1 << m_prev);
                e.seg = hex_tab[m_disp.d[m_prev*4 +: 4]];
                e.dp  = ~m_disp.p[m_prev];
            end
            drn = bnd && (m_pend.size() > 0);
            acc = data_valid && (m_pend.size() == 0 || drn);
            if (drn) m_disp = m_pend.pop_front();
            if (acc) begin
                w = '{d: data, m: data_mask, p: data_dp};
                m_pend.push_back(w);
            end
            e.ack  = acc;
            e.fs   = bnd;
            m_prev = int'(pulse);
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("an", an, e.an);
            chk("seg", {1'b0, seg}, {1'b0, e.seg});
            chk("dp", {7'b0, dp}, {7'b0, e.dp});
            chk("data_ack", {7'b0, data_ack}, {7'b0, e.ack});
            chk("frame_start", {7'b0, frame_start}, {7'b0, e.fs});
        end
    end

    // ---------------- stimulus ----------------
    bit auto_scan = 0;
    int hold_left = 0;

    task automatic tick(input int n = 1);
        word_t w;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (data_valid && data_ack) data_valid = 1'b0;
            if (!data_valid && send_q.size() > 0) begin
                w = send_q.pop_front();
                data = w.d; data_mask = w.m; data_dp = w.p;
                data_valid = 1'b1;
            end
            if (auto_scan) begin
                if (hold_left == 0) begin
                    if ($urandom_range(15) == 0) pulse = 3'($urandom_range(7));
                    else pulse = pulse + 3'd1;
                    hold_left = $urandom_range(1, 24);
                end else begin
                    hold_left--;
                end
            end
        end
    endtask

    task automatic offer(input logic [31:0] d, input logic [7:0] m, input logic [7:0] p);
        word_t w;
        w = '{d: d, m: m, p: p};
        send_q.push_back(w);
    endtask

    // Bounded wait until every queued word has been acknowledged.
    task automatic wait_sent(input string name, input int max);
        int n;
        n = 0;
        tick(1);
        while ((send_q.size() > 0 || data_valid) && n < max) begin
            tick(1);
            n++;
        end
        checks++;
        if (send_q.size() > 0 || data_valid) begin
            errors++;
            $display("FAIL %s: no ack within %0d cycles", name, max);
        end
    endtask

    task automatic scan_digits(input int from, input int to, input int hold);
        for (int d = from; d <= to; d++) begin
            pulse = 3'(d);
            tick(hold);
        end
    endtask

    initial begin
        reset = 1'b0; pulse = 3'd0; data = 32'h0; data_mask = 8'h0; data_dp = 8'h0;
        data_valid = 1'b0;

        // Reset held while the index moves.
        for (int i = 0; i < 3; i++) begin
            pulse = pulse + 3'd1;
            tick(1);
        end
        reset = 1'b1;

        // Load and first frame.
        pulse = 3'd7;
        tick(2);
        offer(32'h7654_3210, 8'hFF, 8'h00);
        wait_sent("ack_first", 20);
        pulse = 3'd0;
        tick(1);
        pulse = 3'd3;
        tick(20);
        pulse = 3'd2;
        tick(20);
        pulse = 3'd3;
        tick(20);

        // Partial mask and decimal point.
        offer(32'hFEDC_BA98, 8'h0F, 8'h01);
        wait_sent("ack_mask", 20);
        pulse = 3'd7;
        tick(3);
        scan_digits(0, 7, 20);

        // Double buffer: A goes to pending, B waits for the swap.
        pulse = 3'd2;
        tick(2);
        offer(32'hAAAA_1111, 8'hFF, 8'hF0);
        offer(32'hBBBB_2222, 8'hFF, 8'h0F);
        tick(20);
        pulse = 3'd7;
        tick(20);
        pulse = 3'd0;
        wait_sent("ack_swap", 10);
        tick(20);
        scan_digits(1, 7, 20);
        scan_digits(0, 3, 20);

        // Reset with pending full and pulse at 5.
        pulse = 3'd5;
        offer(32'hCAFE_F00D, 8'hFF, 8'hFF);
        wait_sent("ack_pre_reset", 20);
        tick(5);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        scan_digits(5, 7, 20);
        scan_digits(0, 7, 20);

        // Randomized scanning, offers and occasional resets.
        auto_scan = 1;
        for (int c = 0; c < 5000; c++) begin
            if (send_q.size() == 0 && !data_valid && $urandom_range(29) == 0)
                offer($urandom, 8'($urandom), 8'($urandom));
            if ($urandom_range(699) == 0) reset = 1'b0;
            else reset = 1'b1;
            tick(1);
        end
        reset = 1'b1;
        auto_scan = 0;
        tick(5);
        repeat (3) @(negedge clk);

        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required at most 1", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
